// File: rtl/cpu_feeder.sv
// Instruction feeder: buffers host words in a FIFO and replays them onto the
// processor's Din/run one instruction at a time. Optional watchdog: CPU_FEEDER_WATCHDOG_EN.
module cpu_feeder #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_valid,
  input  logic [15:0]   wr_data,
  output logic          wr_ready,
  output logic [15:0]   cpu_din,
  output logic          cpu_run,
  input  logic          cpu_done,
  output logic          busy,
  output logic [AW:0]   count,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, WAIT} state_t;

  localparam logic [2:0]  OP_MVI = 3'b001;
  localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);

  state_t        state_reg;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [15:0]   din_reg;
  logic          run_reg;
  logic          hold_first_reg;

  logic          push;
  logic          pop;
  logic [15:0]   head_word;
  logic [15:0]   next_word;
  logic          head_is_mvi;
  logic          head_ready;

  assign wr_ready    = (count_reg != FULL);
  assign push        = wr_valid && wr_ready;
  // The head is popped while issuing; an mvi immediate is popped on the first HOLD cycle.
  assign pop         = (state_reg == ISSUE) || ((state_reg == HOLD) && hold_first_reg);
  assign head_word   = mem[rd_ptr_reg];
  assign next_word   = mem[rd_ptr_reg + AW'(1)];
  assign head_is_mvi = (head_word[8:6] == OP_MVI);
  assign head_ready  = head_is_mvi ? (count_reg >= (AW+1)'(2)) : (count_reg != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef CPU_FEEDER_WATCHDOG_EN
  localparam int          WW      = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  logic [WW-1:0] wd_cnt_reg;
  logic          err_reg;
  assign err = err_reg;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_reg      <= IDLE;
      din_reg        <= '0;
      run_reg        <= 1'b0;
      hold_first_reg <= 1'b0;
`ifdef CPU_FEEDER_WATCHDOG_EN
      wd_cnt_reg     <= '0;
      err_reg        <= 1'b0;
`endif
    end else begin
      run_reg        <= 1'b0;
      hold_first_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (head_ready) begin
            state_reg <= ISSUE;
            run_reg   <= 1'b1;
            din_reg   <= head_word;
          end else begin
            din_reg   <= '0;
          end
        end
        ISSUE: begin
          // Head is still visible this cycle, so the mvi decision and immediate fetch use it.
          if (head_is_mvi) begin
            state_reg      <= HOLD;
            din_reg        <= next_word;
            hold_first_reg <= 1'b1;
          end else begin
            state_reg      <= WAIT;
            din_reg        <= '0;
          end
`ifdef CPU_FEEDER_WATCHDOG_EN
          wd_cnt_reg <= '0;
`endif
        end
        HOLD, WAIT: begin
          if (cpu_done) begin
            state_reg <= IDLE;
            din_reg   <= '0;
          end
`ifdef CPU_FEEDER_WATCHDOG_EN
          else if (wd_cnt_reg == WD_LAST) begin
            err_reg   <= 1'b1;
            state_reg <= IDLE;
            din_reg   <= '0;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + WW'(1);
          end
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cpu_din = din_reg;
  assign cpu_run = run_reg;
  assign busy    = (state_reg != IDLE);
  assign count   = count_reg;

endmodule
